// File: rtl/key_event_queue_pkg.sv
// Shared widths, debounce default and FSM encoding for the key event queue.
// Also holds small bitmap helpers used by the debouncer.
package key_pkg;
    localparam int KEY_CODE_W           = 4;
    localparam int KEY_MAP_W            = 16;
    localparam int DEBOUNCE_SAMPLES_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } deb_state_e;

    function automatic logic [4:0] key_popcount(input logic [KEY_MAP_W-1:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < KEY_MAP_W; i++) c = c + 5'(m[i]);
        return c;
    endfunction

    // Lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KEY_MAP_W-1:0] m);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = KEY_MAP_W - 1; i >= 0; i--) if (m[i]) idx = KEY_CODE_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/key_event_queue_if.sv
// Key event stream: head code plus valid/ready handshake towards the consumer.
interface key_event_queue_if;
    logic [key_pkg::KEY_CODE_W-1:0] key_code;
    logic                           key_valid;
    logic                           key_ready;

    modport master (output key_code, output key_valid, input  key_ready);
    modport slave  (input  key_code, input  key_valid, output key_ready);
endinterface

// File: rtl/key_event_queue_fifo.sv
// First-word fall-through event FIFO with wrap-bit pointers.
// A push while full is accepted only when a pop frees the slot on the same edge.
module key_fifo #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Forced to zero when empty so a stale slot never shows after reset.
    assign head      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data;
    end
endmodule

// File: rtl/key_event_queue.sv
// Keypad debouncer: 60 Hz strobe synchroniser, press/release debounce FSM,
// and a small event FIFO with sticky overflow.
module key_event_queue
    import key_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLK_60HZ,
    input  logic [KEY_MAP_W-1:0] user_input,
    output logic                 multi_key,
    output logic                 overflow,
    key_event_queue_if.master    evt
);
    localparam logic [3:0] DS_N = 4'(DEBOUNCE_SAMPLES);

    logic [2:0]            r_sync;
    logic                  r_tick;
    logic                  r_multi;
    logic                  r_overflow;
    deb_state_e            r_state;
    deb_state_e            w_state_nx;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nx;
    logic [3:0]            w_cnt_inc;
    logic [KEY_CODE_W-1:0] r_cand;
    logic [KEY_CODE_W-1:0] w_cand_nx;
    logic                  w_push;
    logic                  w_single;
    logic                  w_zero;
    logic [KEY_CODE_W-1:0] w_code;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;

    // Two sync flops, third flop for rising-edge detection, registered tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync <= '0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], CLK_60HZ};
            r_tick <= r_sync[1] & ~r_sync[2];
        end
    end

    assign w_single  = (key_popcount(user_input) == 5'd1);
    assign w_zero    = (user_input == '0);
    assign w_code    = key_index(user_input);
    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
            if (r_tick) r_multi <= (key_popcount(user_input) > 5'd1);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_push     = 1'b0;
        if (r_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nx  = w_code;
                        w_cnt_nx   = 4'd1;
                        w_state_nx = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (w_single && (w_code == r_cand)) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == DS_N) begin
                            w_push     = 1'b1;
                            w_state_nx = ST_HELD;
                        end
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end
                end
                // Any non-zero bitmap keeps us held: no repeat, extra keys ignored.
                ST_HELD: begin
                    if (w_zero) begin
                        w_cnt_nx   = 4'd1;
                        w_state_nx = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_zero) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == DS_N) w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_HELD;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign w_pop = evt.key_ready && !w_empty;

    key_fifo #(
        .WIDTH      (KEY_CODE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (w_push),
        .data  (r_cand),
        .pop   (evt.key_ready),
        .head  (evt.key_code),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                         r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end

    assign evt.key_valid = !w_empty;
    assign multi_key     = r_multi;
    assign overflow      = r_overflow;
endmodule
